// File: rtl/xy_mod_pkg.sv
// xy_mod_pkg: shared constants and types for the X mod Y coprocessor
package xy_mod_pkg;
  localparam int XY_WIDTH = 16;
  localparam logic [1:0] XY_ADDR_X = 2'd0;
  localparam logic [1:0] XY_ADDR_Y = 2'd1;
  localparam logic [1:0] XY_ADDR_RES = 2'd2;
  localparam logic [1:0] XY_ADDR_CTRL = 2'd3;
  localparam int CTRL_START = 0;
  localparam int CTRL_IE = 1;
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_DZ = 2;
  localparam int STAT_IE = 3;
  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} xy_state_e;
endpackage

// File: rtl/mod_shift_sub_engine.sv
// mod_shift_sub_engine: restoring shift-subtract remainder, one dividend bit per step
module mod_shift_sub_engine import xy_mod_pkg::*; #(
  parameter int WIDTH = XY_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] rem_nxt,
  output logic             last
);
  logic [WIDTH-1:0] rem, x_sh, y_r;
  logic [$clog2(WIDTH)-1:0] cnt;
  logic [WIDTH:0] t, diff;
  always_comb begin
    t = {rem, x_sh[WIDTH-1]};
    diff = t - {1'b0, y_r};
    rem_nxt = (t >= {1'b0, y_r}) ? diff[WIDTH-1:0] : t[WIDTH-1:0];
  end
  assign last = &cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rem <= '0;
      x_sh <= '0;
      y_r <= '0;
      cnt <= '0;
    end else if (load) begin
      rem <= '0;
      x_sh <= x;
      y_r <= y;
      cnt <= '0;
    end else if (step) begin
      rem <= rem_nxt;
      x_sh <= x_sh << 1;
      cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/xy_mod_seq_ctrl.sv
// xy_mod_seq_ctrl: bus register file and sequencer for the iterative X mod Y engine
module xy_mod_seq_ctrl import xy_mod_pkg::*; #(
  parameter int WIDTH = XY_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             E,
  input  logic             W,
  input  logic             R,
  input  logic [1:0]       ADDR,
  input  logic [WIDTH-1:0] D,
  output logic [31:0]      OUT,
  output logic             IRQ
);
  xy_state_e state;
  logic [WIDTH-1:0] x_r, y_r, result, rem_nxt;
  logic ie, dz, done, last;
  logic wr, rd, calc, ctrl_wr, start, y_zero, load, xy_wr, ie_n, done_n;
  logic [31:0] status, rd_data;
  assign wr = E & W;
  assign rd = E & R;
  assign calc = state == ST_CALC;
  assign ctrl_wr = wr && ADDR == XY_ADDR_CTRL;
  assign start = ctrl_wr && D[CTRL_START] && !calc;
  assign y_zero = y_r == '0;
  assign load = start && !y_zero;
  assign xy_wr = wr && !calc && (ADDR == XY_ADDR_X || ADDR == XY_ADDR_Y);
  assign ie_n = ctrl_wr ? D[CTRL_IE] : ie;
  assign done_n = (calc && last) || (start && y_zero) || (done && !start && !xy_wr);
  always_comb begin
    status = '0;
    status[STAT_BUSY] = calc;
    status[STAT_DONE] = done;
    status[STAT_DZ] = dz;
    status[STAT_IE] = ie;
    rd_data = ADDR == XY_ADDR_X ? 32'(x_r) :
              ADDR == XY_ADDR_Y ? 32'(y_r) :
              ADDR == XY_ADDR_RES ? 32'(result) : status;
  end
  mod_shift_sub_engine #(.WIDTH(WIDTH)) u_engine (
    .clk(CLK),
    .rst_n(RST_N),
    .load(load),
    .step(calc),
    .x(x_r),
    .y(y_r),
    .rem_nxt(rem_nxt),
    .last(last)
  );
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state <= ST_IDLE;
      x_r <= '0;
      y_r <= '0;
      result <= '0;
      ie <= 1'b0;
      dz <= 1'b0;
      done <= 1'b0;
      OUT <= '0;
      IRQ <= 1'b0;
    end else begin
      ie <= ie_n;
      done <= done_n;
      IRQ <= done_n & ie_n;
      if (rd) OUT <= rd_data;
      if (xy_wr) begin
        if (ADDR == XY_ADDR_X) x_r <= D;
        else y_r <= D;
        dz <= 1'b0;
        state <= ST_IDLE;
      end
      if (start) begin
        state <= y_zero ? ST_DONE : ST_CALC;
        dz <= y_zero;
        if (y_zero) result <= x_r;
      end
      if (calc && last) begin
        result <= rem_nxt;
        state <= ST_DONE;
      end
    end
endmodule

// File: tb/tb_xy_mod_seq_ctrl.sv
// tb_xy_mod_seq_ctrl: directed bus-level checks of the X mod Y coprocessor
module tb_xy_mod_seq_ctrl;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic E = 1'b0, W = 1'b0, R = 1'b0;
  logic [1:0] ADDR = '0;
  logic [15:0] D = '0;
  logic [31:0] OUT;
  logic IRQ;
  int n_chk = 0;
  int n_fail = 0;
  xy_mod_seq_ctrl dut (
    .CLK(CLK), .RST_N(RST_N), .E(E), .W(W), .R(R),
    .ADDR(ADDR), .D(D), .OUT(OUT), .IRQ(IRQ)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic bus(input logic w, input logic r, input logic [1:0] a, input logic [15:0] d);
    @(negedge CLK);
    E = 1'b1; W = w; R = r; ADDR = a; D = d;
    @(posedge CLK);
    #1;
    E = 1'b0; W = 1'b0; R = 1'b0;
  endtask
  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    bus(1'b0, 1'b1, a, 16'h0);
    check(tag, OUT, exp);
  endtask
  task automatic poll(input string tag, input int n, input logic [31:0] busy_v, input logic [31:0] done_v);
    for (int i = 0; i < n; i++) rd_chk({tag, "_busy"}, 2'd3, busy_v);
    rd_chk({tag, "_done"}, 2'd3, done_v);
  endtask
  task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                        input logic ie, input logic [31:0] exp);
    bus(1'b1, 1'b0, 2'd0, x);
    bus(1'b1, 1'b0, 2'd1, y);
    bus(1'b1, 1'b0, 2'd3, {14'h0, ie, 1'b1});
    poll(tag, 16, {28'h0, ie, 3'b001}, {28'h0, ie, 3'b010});
    rd_chk({tag, "_res"}, 2'd2, exp);
    check({tag, "_irq"}, {31'h0, IRQ}, {31'h0, ie});
  endtask
  initial begin
    #12;
    check("rst_out", OUT, 32'h0);
    check("rst_irq", {31'h0, IRQ}, 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    rd_chk("rst_status", 2'd3, 32'h0);
    rd_chk("rst_res", 2'd2, 32'h0);
    run_op("m100_7", 16'd100, 16'd7, 1'b0, 32'd2);
    run_op("m5_9", 16'd5, 16'd9, 1'b0, 32'd5);
    run_op("mffff_1", 16'hFFFF, 16'd1, 1'b0, 32'd0);
    run_op("mffff_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 32'd0);
    run_op("m40000_300", 16'd40000, 16'd300, 1'b0, 32'd100);
    bus(1'b1, 1'b0, 2'd0, 16'h1234);
    bus(1'b1, 1'b0, 2'd1, 16'h0);
    bus(1'b1, 1'b0, 2'd3, 16'h1);
    rd_chk("dz_status", 2'd3, 32'h6);
    rd_chk("dz_res", 2'd2, 32'h1234);
    bus(1'b1, 1'b0, 2'd0, 16'h0005);
    rd_chk("dz_clear", 2'd3, 32'h0);
    bus(1'b1, 1'b0, 2'd0, 16'd100);
    bus(1'b1, 1'b0, 2'd1, 16'd7);
    bus(1'b1, 1'b0, 2'd3, 16'h1);
    bus(1'b1, 1'b0, 2'd0, 16'd3);
    bus(1'b1, 1'b0, 2'd1, 16'd2);
    bus(1'b1, 1'b0, 2'd3, 16'h1);
    rd_chk("ign_res_old", 2'd2, 32'h1234);
    poll("ign", 12, 32'h1, 32'h2);
    rd_chk("ign_res", 2'd2, 32'd2);
    rd_chk("ign_x", 2'd0, 32'd100);
    rd_chk("ign_y", 2'd1, 32'd7);
    run_op("irq", 16'd1000, 16'd13, 1'b1, 32'd12);
    bus(1'b1, 1'b0, 2'd3, 16'h0);
    check("irq_drop", {31'h0, IRQ}, 32'h0);
    rd_chk("irq_status", 2'd3, 32'h2);
    bus(1'b1, 1'b0, 2'd0, 16'd100);
    bus(1'b1, 1'b0, 2'd3, 16'h1);
    for (int i = 0; i < 8; i++) rd_chk("rst_mid_busy", 2'd3, 32'h1);
    RST_N = 1'b0;
    #1;
    check("rstmid_out", OUT, 32'h0);
    check("rstmid_irq", {31'h0, IRQ}, 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    rd_chk("rstmid_status", 2'd3, 32'h0);
    rd_chk("rstmid_res", 2'd2, 32'h0);
    rd_chk("rstmid_x", 2'd0, 32'h0);
    bus(1'b1, 1'b0, 2'd0, 16'h0055);
    rd_chk("x55", 2'd0, 32'h55);
    @(negedge CLK);
    E = 1'b0; W = 1'b1; R = 1'b1; ADDR = 2'd1; D = 16'hABCD;
    @(posedge CLK);
    #1;
    W = 1'b0; R = 1'b0;
    check("e0_out", OUT, 32'h55);
    rd_chk("e0_y", 2'd1, 32'h0);
    bus(1'b1, 1'b1, 2'd0, 16'h0077);
    check("wr_rd_pre", OUT, 32'h55);
    rd_chk("wr_rd_post", 2'd0, 32'h77);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
